// File: rtl/lsu_axil_pkg.sv
// Shared definitions for the LSU AXI4-Lite initiator: access size codes,
// AXI response codes, FSM state encoding and the alignment check.
package lsu_axil_pkg;

   // LSU access size codes
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // AXI response codes
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE_ENC = 3'd0;
   localparam logic [2:0] ST_RD_A_ENC = 3'd1;
   localparam logic [2:0] ST_RD_D_ENC = 3'd2;
   localparam logic [2:0] ST_WR_ENC   = 3'd3;
   localparam logic [2:0] ST_WR_B_ENC = 3'd4;
   localparam logic [2:0] ST_RESP_ENC = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE = ST_IDLE_ENC,
      ST_RD_A = ST_RD_A_ENC,
      ST_RD_D = ST_RD_D_ENC,
      ST_WR   = ST_WR_ENC,
      ST_WR_B = ST_WR_B_ENC,
      ST_RESP = ST_RESP_ENC
   } state_t;

   // A half must sit on an even byte, a word on a 4-byte boundary; size 11 is never legal.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the LSU and a 32-bit bus.
// Store side: shifts right-justified store data onto its lanes and builds wstrb.
// Load side: shifts the addressed bytes down to bit 0 and sign/zero-extends.
module lsu_lane_align
   import lsu_axil_pkg::*;
(
   input  logic [1:0]  i_st_off,
   input  logic [1:0]  i_st_size,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_st_data,
   output logic [3:0]  o_st_strb,
   input  logic [1:0]  i_ld_off,
   input  logic [1:0]  i_ld_size,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_ld_data,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_ld_shift;

   // Store lane placement and byte strobes
   always_comb begin
      o_st_data = i_st_data << {i_st_off, 3'b000};
      case (i_st_size)
         SZ_B:    o_st_strb = 4'b0001 << i_st_off;
         SZ_H:    o_st_strb = 4'b0011 << i_st_off;
         default: o_st_strb = 4'b1111;
      endcase
   end

   // Load extraction and extension; size 11 only reaches here with the check disabled
   always_comb begin
      w_ld_shift = i_ld_data >> {i_ld_off, 3'b000};
      case (i_ld_size)
         SZ_B: begin
            if (i_ld_unsigned) begin
               o_ld_data = {24'h000000, w_ld_shift[7:0]};
            end else begin
               o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            end
         end
         SZ_H: begin
            if (i_ld_unsigned) begin
               o_ld_data = {16'h0000, w_ld_shift[15:0]};
            end else begin
               o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            end
         end
         default: o_ld_data = w_ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_axil_master.sv
// AXI4-Lite initiator for the load/store unit. One transaction at a time:
// IDLE -> RD_A -> RD_D -> RESP for loads, IDLE -> WR -> WR_B -> RESP for stores,
// IDLE -> RESP for misaligned requests. All bus-facing valids/readies are flops
// loaded from the next-state decode, so they never glitch and hold until handshake.
module lsu_axil_master
   import lsu_axil_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int MISALIGN_CHECK = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   // LSU request
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [1:0]        i_req_size,
   input  logic              i_req_unsigned,
   input  logic [31:0]       i_req_wdata,
   // LSU response
   output logic              o_resp_valid,
   input  logic              i_resp_ready,
   output logic [31:0]       o_resp_rdata,
   output logic              o_resp_err,
   // AXI read address / data
   output logic [ADDR_W-1:0] o_araddr,
   output logic              o_arvalid,
   input  logic              i_arready,
   input  logic [31:0]       i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rvalid,
   output logic              o_rready,
   // AXI write address / data / response
   output logic [ADDR_W-1:0] o_awaddr,
   output logic              o_awvalid,
   input  logic              i_awready,
   output logic [31:0]       o_wdata,
   output logic [3:0]        o_wstrb,
   output logic              o_wvalid,
   input  logic              i_wready,
   input  logic [1:0]        i_bresp,
   input  logic              i_bvalid,
   output logic              o_bready
);

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic [31:0]       r_rdata;
   logic              r_err;
   logic              r_aw_done;
   logic              r_w_done;

   logic              r_req_ready;
   logic              r_arvalid;
   logic              r_rready;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_bready;
   logic              r_resp_valid;

   logic              w_accept;
   logic              w_misalign;
   logic              w_ar_hs;
   logic              w_r_hs;
   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_b_hs;
   logic              w_resp_hs;
   logic              w_aw_done_nxt;
   logic              w_w_done_nxt;
   logic [31:0]       w_st_data;
   logic [3:0]        w_st_strb;
   logic [31:0]       w_ld_data;

   assign w_accept   = r_req_ready && i_req_valid;
   assign w_misalign = (MISALIGN_CHECK != 0) && is_misaligned(i_req_size, i_req_addr[1:0]);
   assign w_ar_hs    = r_arvalid && i_arready;
   assign w_r_hs     = r_rready && i_rvalid;
   assign w_aw_hs    = r_awvalid && i_awready;
   assign w_w_hs     = r_wvalid && i_wready;
   assign w_b_hs     = r_bready && i_bvalid;
   assign w_resp_hs  = r_resp_valid && i_resp_ready;

   // Store lanes come from the live request (registered at accept);
   // load extraction uses the registered offset/size against live rdata.
   lsu_lane_align u_lane_align (
      .i_st_off      (i_req_addr[1:0]),
      .i_st_size     (i_req_size),
      .i_st_data     (i_req_wdata),
      .o_st_data     (w_st_data),
      .o_st_strb     (w_st_strb),
      .i_ld_off      (r_addr[1:0]),
      .i_ld_size     (r_size),
      .i_ld_unsigned (r_unsigned),
      .i_ld_data     (i_rdata),
      .o_ld_data     (w_ld_data)
   );

   // AW/W completion flags: cleared on accept, set by each channel's handshake
   always_comb begin
      w_aw_done_nxt = r_aw_done;
      w_w_done_nxt  = r_w_done;
      if (w_accept) begin
         w_aw_done_nxt = 1'b0;
         w_w_done_nxt  = 1'b0;
      end else begin
         w_aw_done_nxt = r_aw_done || w_aw_hs;
         w_w_done_nxt  = r_w_done || w_w_hs;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_misalign) begin
                  w_state_nxt = ST_RESP;
               end else if (i_req_we) begin
                  w_state_nxt = ST_WR;
               end else begin
                  w_state_nxt = ST_RD_A;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RD_A: begin
            if (w_ar_hs) begin
               w_state_nxt = ST_RD_D;
            end else begin
               w_state_nxt = ST_RD_A;
            end
         end
         ST_RD_D: begin
            if (w_r_hs) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_RD_D;
            end
         end
         ST_WR: begin
            if (w_aw_done_nxt && w_w_done_nxt) begin
               w_state_nxt = ST_WR_B;
            end else begin
               w_state_nxt = ST_WR;
            end
         end
         ST_WR_B: begin
            if (w_b_hs) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_WR_B;
            end
         end
         ST_RESP: begin
            if (w_resp_hs) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RESP;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered handshake outputs decoded from the next state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_resp_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_req_ready  <= (w_state_nxt == ST_IDLE);
         r_arvalid    <= (w_state_nxt == ST_RD_A);
         r_rready     <= (w_state_nxt == ST_RD_D);
         r_awvalid    <= (w_state_nxt == ST_WR) && !w_aw_done_nxt;
         r_wvalid     <= (w_state_nxt == ST_WR) && !w_w_done_nxt;
         r_bready     <= (w_state_nxt == ST_WR_B);
         r_resp_valid <= (w_state_nxt == ST_RESP);
      end
   end

   // Request capture, bus result capture and write-channel flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr     <= '0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_wdata    <= 32'h0000_0000;
         r_wstrb    <= 4'b0000;
         r_rdata    <= 32'h0000_0000;
         r_err      <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
      end else begin
         r_aw_done <= w_aw_done_nxt;
         r_w_done  <= w_w_done_nxt;
         if (w_accept) begin
            r_addr     <= i_req_addr;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_wdata    <= (i_req_we && !w_misalign) ? w_st_data : 32'h0000_0000;
            r_wstrb    <= (i_req_we && !w_misalign) ? w_st_strb : 4'b0000;
            r_rdata    <= 32'h0000_0000;
            r_err      <= w_misalign;
         end else if (w_r_hs) begin
            r_rdata <= w_ld_data;
            r_err   <= (i_rresp != OKAY);
         end else if (w_b_hs) begin
            r_err <= (i_bresp != OKAY);
         end else begin
            r_err <= r_err;
         end
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;
   assign o_araddr     = r_addr;
   assign o_arvalid    = r_arvalid;
   assign o_rready     = r_rready;
   assign o_awaddr     = r_addr;
   assign o_awvalid    = r_awvalid;
   assign o_wdata      = r_wdata;
   assign o_wstrb      = r_wstrb;
   assign o_wvalid     = r_wvalid;
   assign o_bready     = r_bready;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Self-checking bench for lsu_axil_master. A cycle-level AXI-Lite responder
// runs inside each transaction; expected LSU results are queued when a request
// is issued and popped when the DUT presents its response.
module tb_lsu_axil_master;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid, i_req_we, i_req_unsigned;
   logic [31:0] i_req_addr, i_req_wdata;
   logic [1:0]  i_req_size;
   logic        o_req_ready, o_resp_valid, o_resp_err;
   logic        i_resp_ready;
   logic [31:0] o_resp_rdata;
   logic [31:0] o_araddr, o_awaddr, o_wdata, i_rdata;
   logic        o_arvalid, i_arready, i_rvalid, o_rready;
   logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
   logic [1:0]  i_rresp, i_bresp;
   logic [3:0]  o_wstrb;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   lsu_axil_master #(.ADDR_W(32), .MISALIGN_CHECK(1)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
      .i_req_wdata(i_req_wdata),
      .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
      .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
      .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
      .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
      .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference load extraction, byte-by-byte
   function automatic logic [31:0] ref_load(input logic [1:0] off, input logic [1:0] sz,
                                            input logic uns, input logic [31:0] d);
      logic [7:0] b0, b1;
      case (off)
         2'd0: begin b0 = d[7:0];   b1 = d[15:8];  end
         2'd1: begin b0 = d[15:8];  b1 = d[23:16]; end
         2'd2: begin b0 = d[23:16]; b1 = d[31:24]; end
         default: begin b0 = d[31:24]; b1 = 8'h00; end
      endcase
      case (sz)
         2'b00: return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
         2'b01: return uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] ref_strb(input logic [1:0] off, input logic [1:0] sz);
      case (sz)
         2'b00: case (off)
                   2'd0: return 4'b0001;
                   2'd1: return 4'b0010;
                   2'd2: return 4'b0100;
                   default: return 4'b1000;
                endcase
         2'b01: return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] off, input logic [31:0] wd);
      case (off)
         2'd0: return wd;
         2'd1: return {wd[23:0], 8'h00};
         2'd2: return {wd[15:0], 16'h0000};
         default: return {wd[7:0], 24'h000000};
      endcase
   endfunction

   task automatic idle_bus();
      i_req_valid = 1'b0; i_resp_ready = 1'b0;
      i_arready = 1'b0; i_rvalid = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
      i_rdata = 32'h0; i_rresp = 2'b00; i_bresp = 2'b00;
   endtask

   // One full transaction with a cycle-accurate responder.
   task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wd,
                          input logic [31:0] bus_rd, input logic [1:0] bus_resp,
                          input int aw_dly, input int w_dly, input int hold,
                          input logic exp_bus, input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
      int cyc = 0, viol = 0, rv_cyc = -1, ar_first = -1, aw_first = -1;
      int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
      bit done = 0;
      bit ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
      bit ar_p = 0, r_p = 0, aw_p = 0, w_p = 0, b_p = 0;
      bit pv_ar = 0, pv_aw = 0, pv_w = 0;
      logic [31:0] pa_ar = 0, pa_aw = 0, pd_w = 0, hs_ar = 0, hs_aw = 0, hs_wd = 0, rv_data = 0;
      logic [3:0]  ps_w = 0, hs_ws = 0;
      logic        rv_err = 0;
      exp_t        e;
      @(negedge clk);
      chk({name, ".req_ready"}, 32'(o_req_ready), 32'd1);
      i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_size = size;
      i_req_unsigned = uns; i_req_wdata = wd;
      sb_q.push_back('{rdata: exp_rdata, err: exp_err});
      while (!done && cyc < 80) begin
         @(negedge clk);
         cyc++;
         i_req_valid = 1'b0;
         if (ar_p) ar_d = 1; if (r_p) r_d = 1; if (aw_p) aw_d = 1; if (w_p) w_d = 1; if (b_p) b_d = 1;
         ar_p = 0; r_p = 0; aw_p = 0; w_p = 0; b_p = 0;
         if (pv_ar && (!o_arvalid || o_araddr !== pa_ar)) viol++;
         if (pv_aw && (!o_awvalid || o_awaddr !== pa_aw)) viol++;
         if (pv_w && (!o_wvalid || o_wdata !== pd_w || o_wstrb !== ps_w)) viol++;
         if (o_bready && !(aw_d && w_d)) viol++;
         if (o_arvalid && ar_first < 0) ar_first = cyc;
         if (o_awvalid && aw_first < 0) aw_first = cyc;
         i_arready = 1'b1;
         i_awready = (cyc >= aw_dly);
         i_wready  = (cyc >= w_dly);
         i_rvalid  = ar_d && !r_d; i_rdata = bus_rd; i_rresp = bus_resp;
         i_bvalid  = aw_d && w_d && !b_d; i_bresp = bus_resp;
         if (o_arvalid && i_arready) begin ar_cnt++; ar_p = 1; hs_ar = o_araddr; end
         if (o_rready && i_rvalid) r_p = 1;
         if (o_awvalid && i_awready) begin aw_cnt++; aw_p = 1; hs_aw = o_awaddr; end
         if (o_wvalid && i_wready) begin w_cnt++; w_p = 1; hs_wd = o_wdata; hs_ws = o_wstrb; end
         if (o_bready && i_bvalid) begin b_cnt++; b_p = 1; end
         pv_ar = o_arvalid && !i_arready; pa_ar = o_araddr;
         pv_aw = o_awvalid && !i_awready; pa_aw = o_awaddr;
         pv_w  = o_wvalid && !i_wready;   pd_w = o_wdata; ps_w = o_wstrb;
         if (o_resp_valid) begin
            if (rv_cyc < 0) begin
               rv_cyc = cyc; rv_data = o_resp_rdata; rv_err = o_resp_err;
            end else if (o_resp_rdata !== rv_data || o_resp_err !== rv_err) begin
               viol++;
            end
            i_resp_ready = ((cyc - rv_cyc) >= hold);
            if (i_resp_ready) begin
               e = sb_q.pop_front();
               chk({name, ".rdata"}, o_resp_rdata, e.rdata);
               chk({name, ".err"}, 32'(o_resp_err), 32'(e.err));
               done = 1;
            end
         end else begin
            i_resp_ready = 1'b0;
         end
      end
      chk({name, ".completed"}, 32'(done), 32'd1);
      if (!done) sb_q.delete();
      chk({name, ".ar_count"}, 32'(ar_cnt), (exp_bus && !we) ? 32'd1 : 32'd0);
      chk({name, ".aw_count"}, 32'(aw_cnt), (exp_bus && we) ? 32'd1 : 32'd0);
      chk({name, ".w_count"},  32'(w_cnt),  (exp_bus && we) ? 32'd1 : 32'd0);
      chk({name, ".b_count"},  32'(b_cnt),  (exp_bus && we) ? 32'd1 : 32'd0);
      chk({name, ".protocol"}, 32'(viol), 32'd0);
      if (exp_bus && we) begin
         chk({name, ".awaddr"}, hs_aw, addr);
         chk({name, ".wdata"}, hs_wd, exp_wdata);
         chk({name, ".wstrb"}, 32'(hs_ws), 32'(exp_wstrb));
         chk({name, ".aw_first_cycle"}, 32'(aw_first), 32'd1);
      end else if (exp_bus) begin
         chk({name, ".araddr"}, hs_ar, addr);
         chk({name, ".ar_first_cycle"}, 32'(ar_first), 32'd1);
      end else begin
         chk({name, ".first_valid"}, 32'(ar_first < 0 && aw_first < 0), 32'd1);
      end
      chk({name, ".latency_ok"}, 32'(rv_cyc >= (exp_bus ? 3 : 1)), 32'd1);
      @(negedge clk);
      idle_bus();
      chk({name, ".back_idle"}, {30'd0, o_resp_valid, o_req_ready}, 32'd1);
   endtask

   initial begin : main
      int cyc;
      bit seen;
      logic [31:0] a, wd, rd;
      logic [1:0]  sz, rsp;
      logic        we, uns;
      idle_bus();
      i_req_we = 1'b0; i_req_addr = 32'h0; i_req_size = 2'b00; i_req_unsigned = 1'b0;
      i_req_wdata = 32'h0;
      i_rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset.handshakes", {25'd0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                               o_resp_valid, o_req_ready}, 32'd1);
      chk("reset.araddr", o_araddr, 32'h0);
      chk("reset.wdata", o_wdata, 32'h0);
      chk("reset.resp_rdata", {o_resp_rdata[30:0], o_resp_err}, 32'h0);
      i_rst = 1'b0;

      run_txn("st_b_a5", 1'b1, 32'h1000_0003, 2'b00, 1'b0, 32'h0000_00A5, 32'h0, 2'b00,
              1, 1, 0, 1'b1, 32'h0, 1'b0, 32'hA500_0000, 4'b1000);
      run_txn("ld_h_s", 1'b0, 32'h8000_0002, 2'b01, 1'b0, 32'h0, 32'h8001_1234, 2'b00,
              1, 1, 0, 1'b1, 32'hFFFF_8001, 1'b0, 32'h0, 4'b0);
      run_txn("ld_h_u", 1'b0, 32'h8000_0002, 2'b01, 1'b1, 32'h0, 32'h8001_1234, 2'b00,
              1, 1, 0, 1'b1, 32'h0000_8001, 1'b0, 32'h0, 4'b0);
      run_txn("st_w_skew", 1'b1, 32'h2000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 2'b00,
              4, 1, 0, 1'b1, 32'h0, 1'b0, 32'hDEAD_BEEF, 4'b1111);
      run_txn("st_h_skew", 1'b1, 32'h2000_0012, 2'b01, 1'b0, 32'h0000_5A3C, 32'h0, 2'b00,
              1, 3, 1, 1'b1, 32'h0, 1'b0, 32'h5A3C_0000, 4'b1100);
      run_txn("ld_w_mis", 1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 2'b00,
              1, 1, 0, 1'b0, 32'h0, 1'b1, 32'h0, 4'b0);
      run_txn("st_h_mis", 1'b1, 32'h0000_0101, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0, 2'b00,
              1, 1, 0, 1'b0, 32'h0, 1'b1, 32'h0, 4'b0);
      run_txn("ld_sz3", 1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0, 32'h1234_5678, 2'b00,
              1, 1, 0, 1'b0, 32'h0, 1'b1, 32'h0, 4'b0);
      run_txn("st_slverr", 1'b1, 32'h4000_0000, 2'b10, 1'b0, 32'h0BAD_F00D, 32'h0, 2'b10,
              1, 1, 5, 1'b1, 32'h0, 1'b1, 32'h0BAD_F00D, 4'b1111);
      run_txn("ld_decerr", 1'b0, 32'h4000_0000, 2'b00, 1'b0, 32'h0, 32'h0000_00F0, 2'b11,
              1, 1, 5, 1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0, 4'b0);

      // Reset while waiting in RD_D for rvalid
      @(negedge clk);
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h3000_0000; i_req_size = 2'b10;
      i_arready = 1'b1; i_rvalid = 1'b0;
      cyc = 0; seen = 0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         i_req_valid = 1'b0;
         if (o_rready) seen = 1;
      end
      chk("rst_rd.rready_seen", 32'(seen), 32'd1);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      idle_bus();
      chk("rst_rd.handshakes", {25'd0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                                o_resp_valid, o_req_ready}, 32'd1);
      run_txn("ld_after_rst", 1'b0, 32'h3000_0001, 2'b00, 1'b1, 32'h0, 32'h0000_C300, 2'b00,
              1, 1, 0, 1'b1, 32'h0000_00C3, 1'b0, 32'h0, 4'b0);

      // Randomised aligned traffic with occasional bus errors
      for (int i = 0; i < 12; i++) begin
         we  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 2));
         a   = $urandom;
         if (sz == 2'b01) a[0] = 1'b0;
         if (sz == 2'b10) a[1:0] = 2'b00;
         wd  = $urandom;
         rd  = $urandom;
         rsp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
         run_txn("rand", we, a, sz, uns, wd, rd, rsp,
                 $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2), 1'b1,
                 we ? 32'h0 : ref_load(a[1:0], sz, uns, rd), (rsp != 2'b00),
                 ref_wdata(a[1:0], wd), ref_strb(a[1:0], sz));
      end

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
